// File: rtl/scaler_pkg.sv
// scaler_pkg
//   Shared constants, FSM state type and buffer-index helper for the
//   vertical scaler line scheduler.
//   Contents:
//     NUM_LINE_BUF : number of line buffers in the ring (5)
//     FRAC_W       : fractional bits of the vertical source position (12)
//     STEP_ONE     : step value meaning 1.0 source line per output line
//     v_state_e    : scheduler FSM states
//     buf_of(k)    : ring buffer holding source line k

package scaler_pkg;

    localparam int NUM_LINE_BUF = 5;
    localparam int FRAC_W       = 12;
    localparam int STEP_ONE     = 4096;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE,
        BUSY
    } v_state_e;

    // Source line k is always written into buffer k mod NUM_LINE_BUF.
    function automatic logic [2:0] buf_of(input logic [31:0] k);
        return 3'(k % 32'(NUM_LINE_BUF));
    endfunction

endpackage

// File: rtl/scaler_v_ctrl_if.sv
// scaler_v_ctrl_if
//   Video timing, line-buffer select and datapath handshake signals of the
//   vertical scaler line scheduler.
//   Parameters: PHASE_W - width of the interpolation phase.
//   Signals:
//     hs_i, vs_i      : source line end / frame start pulses
//     line_done       : datapath finished the current output line
//     wr_sel          : buffer currently being written
//     rd_sel0..3      : buffers for source lines n-1 .. n+2
//     phase           : coefficient phase
//     line_go         : start of an output line
//     frame_done      : last output line of the frame completed
//     ovf             : sticky overwrite-of-unread-line flag
//   Modports: master = scheduler side, slave = video/datapath side.

interface scaler_v_ctrl_if #(
    parameter int PHASE_W = 4
);

    logic               hs_i;
    logic               vs_i;
    logic               line_done;
    logic [2:0]         wr_sel;
    logic [2:0]         rd_sel0;
    logic [2:0]         rd_sel1;
    logic [2:0]         rd_sel2;
    logic [2:0]         rd_sel3;
    logic [PHASE_W-1:0] phase;
    logic               line_go;
    logic               frame_done;
    logic               ovf;

    modport master (
        input  hs_i, vs_i, line_done,
        output wr_sel, rd_sel0, rd_sel1, rd_sel2, rd_sel3,
        output phase, line_go, frame_done, ovf
    );

    modport slave (
        output hs_i, vs_i, line_done,
        input  wr_sel, rd_sel0, rd_sel1, rd_sel2, rd_sel3,
        input  phase, line_go, frame_done, ovf
    );

endinterface

// File: rtl/scaler_v_pos_acc.sv
// scaler_v_pos_acc
//   Fixed-point vertical source position accumulator (LINE_CNT_W.FRAC_W).
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     load      : frame start, latch step_in and clear the position
//     step_in   : source lines per output line, unsigned 4.12
//     advance   : add the step once (output line completed)
//     line_n    : integer part of the position
//     phase     : top PHASE_W bits of the fractional part

module scaler_v_pos_acc
    import scaler_pkg::*;
#(
    parameter int PHASE_W    = 4,
    parameter int LINE_CNT_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [15:0]           step_in,
    input  logic                  advance,
    output logic [LINE_CNT_W-1:0] line_n,
    output logic [PHASE_W-1:0]    phase
);

    localparam int POS_W = LINE_CNT_W + FRAC_W;

    logic [15:0]      step;
    logic [POS_W-1:0] pos;

    // A zero step would freeze the position forever, so it is treated as 1.0.
    // Load has priority so an abort mid-line discards any pending advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            step <= 16'(STEP_ONE);
            pos  <= '0;
        end else if (load) begin
            step <= (step_in == 16'd0) ? 16'(STEP_ONE) : step_in;
            pos  <= '0;
        end else if (advance) begin
            pos  <= pos + POS_W'(step);
        end
    end

    assign line_n = pos[POS_W-1:FRAC_W];
    assign phase  = pos[FRAC_W-1 -: PHASE_W];

endmodule

// File: rtl/scaler_v_ctrl.sv
// scaler_v_ctrl
//   Line scheduler for the vertical scaler. Counts source lines written into
//   a ring of five line buffers, tracks the vertical source position and, for
//   each output line, selects four source buffers plus the phase and starts
//   the datapath with a line_go / line_done handshake.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     v_scale_step      : source lines per output line, unsigned 4.12
//     v_scale_line_size : output lines per frame
//     bus (master)      : timing inputs, buffer selects, phase, handshake
//   Build option:
//     SCALER_V_CTRL_OVF_DET_EN - when defined, ovf latches whenever a new
//     source line overwrites a buffer still needed by the line in flight;
//     otherwise ovf is constant 0.

module scaler_v_ctrl
    import scaler_pkg::*;
#(
    parameter int PHASE_W    = 4,
    parameter int LINE_CNT_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] v_scale_step,
    input  logic [15:0] v_scale_line_size,
    scaler_v_ctrl_if.master bus
);

    // Signed width large enough for n-1+3 and src_cnt-1 without wrapping.
    localparam int IW = LINE_CNT_W + 2;

    v_state_e              state;
    logic [LINE_CNT_W-1:0] src_cnt;
    logic [LINE_CNT_W-1:0] out_cnt;
    logic [15:0]           lines;
    logic [2:0]            wr_sel_q;
    logic [3:0][2:0]       rd_sel_q;
    logic [3:0][2:0]       rd_sel_next;
    logic [PHASE_W-1:0]    phase_q;
    logic [PHASE_W-1:0]    phase_acc;
    logic [LINE_CNT_W-1:0] line_n;
    logic                  line_go_q;
    logic                  frame_done_q;
    logic                  ovf_q;
    logic                  src_ready;
    logic                  acc_advance;

    // Buffer for row x of the 4-tap window: source line n-1+x clamped to the
    // lines received so far, so the top row replicates line 0.
    function automatic logic [2:0] sel_for(
        input logic [LINE_CNT_W-1:0] n,
        input logic [LINE_CNT_W-1:0] cnt,
        input int                    x
    );
        logic signed [IW-1:0] idx;
        logic signed [IW-1:0] top;
        idx = IW'(n) + IW'(x) - IW'(1);
        top = IW'(cnt) - IW'(1);
        if (idx > top) idx = top;
        if (idx < 0)   idx = '0;
        return buf_of(32'(idx[LINE_CNT_W-1:0]));
    endfunction

    assign acc_advance = (state == BUSY) && bus.line_done && !bus.vs_i;

    scaler_v_pos_acc #(
        .PHASE_W    (PHASE_W),
        .LINE_CNT_W (LINE_CNT_W)
    ) u_pos_acc (
        .clk     (clk),
        .rst     (rst),
        .load    (bus.vs_i),
        .step_in (v_scale_step),
        .advance (acc_advance),
        .line_n  (line_n),
        .phase   (phase_acc)
    );

    // A line can start once source lines n-1..n+2 are all in the ring.
    assign src_ready = ({1'b0, src_cnt} >= ({1'b0, line_n} + (LINE_CNT_W+1)'(3)));

    // Candidate selects for the next line; only sampled on entry to ISSUE.
    always_comb begin
        rd_sel_next = '0;
        for (int x = 0; x < 4; x++) begin
            rd_sel_next[x] = sel_for(line_n, src_cnt, x);
        end
    end

    // Scheduler FSM with source counting. vs_i restarts everything and wins
    // over a simultaneous hs_i; a line_done seen outside BUSY is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lines        <= '0;
            src_cnt      <= '0;
            out_cnt      <= '0;
            wr_sel_q     <= '0;
            rd_sel_q     <= '0;
            phase_q      <= '0;
            line_go_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            line_go_q    <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.vs_i) begin
                lines    <= v_scale_line_size;
                src_cnt  <= '0;
                out_cnt  <= '0;
                wr_sel_q <= '0;
                state    <= WAIT;
            end else begin
                if (bus.hs_i) begin
                    if (src_cnt != '1) begin
                        src_cnt <= src_cnt + LINE_CNT_W'(1);
                    end
                    wr_sel_q <= (wr_sel_q == 3'(NUM_LINE_BUF - 1)) ? 3'd0 : wr_sel_q + 3'd1;
                end
                case (state)
                    IDLE: ;
                    WAIT: begin
                        if (16'(out_cnt) == lines) begin
                            frame_done_q <= 1'b1;
                            state        <= IDLE;
                        end else if (src_ready) begin
                            line_go_q <= 1'b1;
                            rd_sel_q  <= rd_sel_next;
                            phase_q   <= phase_acc;
                            state     <= ISSUE;
                        end
                    end
                    ISSUE: state <= BUSY;
                    BUSY: begin
                        if (bus.line_done) begin
                            out_cnt <= out_cnt + LINE_CNT_W'(1);
                            state   <= WAIT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SCALER_V_CTRL_OVF_DET_EN
    logic ovf_hit;

    // Overwrite when the incoming line would leave more than five lines
    // between row n-1 of the line in flight and the write pointer:
    // (src_cnt+1) - (n-1) > 5, rearranged to stay unsigned.
    assign ovf_hit = bus.hs_i && !bus.vs_i && ((state == ISSUE) || (state == BUSY)) &&
                     ((IW'(src_cnt) + IW'(2)) > (IW'(line_n) + IW'(5)));

    // Sticky until reset so software can see a single lost line.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (ovf_hit) begin
            ovf_q <= 1'b1;
        end
    end
`else
    assign ovf_q = 1'b0;
`endif

    assign bus.wr_sel     = wr_sel_q;
    assign bus.rd_sel0    = rd_sel_q[0];
    assign bus.rd_sel1    = rd_sel_q[1];
    assign bus.rd_sel2    = rd_sel_q[2];
    assign bus.rd_sel3    = rd_sel_q[3];
    assign bus.phase      = phase_q;
    assign bus.line_go    = line_go_q;
    assign bus.frame_done = frame_done_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_scaler_v_ctrl.sv
// tb_scaler_v_ctrl
//   Self-checking bench for scaler_v_ctrl. Expected buffer selects and phase
//   for every output line are queued when a frame is started and compared
//   when the scheduler raises line_go. A responder plays the datapath and
//   returns line_done a programmable number of cycles after each line_go.
//   Honours SCALER_V_CTRL_OVF_DET_EN for the expected ovf value.

module tb_scaler_v_ctrl;

`ifdef SCALER_V_CTRL_OVF_DET_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] v_scale_step;
    logic [15:0] v_scale_line_size;

    scaler_v_ctrl_if #(.PHASE_W(4)) bus();

    scaler_v_ctrl #(
        .PHASE_W    (4),
        .LINE_CNT_W (12)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .v_scale_step      (v_scale_step),
        .v_scale_line_size (v_scale_line_size),
        .bus               (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb[$];
    int          go_cnt = 0;
    int          fd_cnt = 0;
    int          hold_bad = 0;
    int          done_delay = 5;
    logic [15:0] last_sel = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] cur_sel();
        return {bus.rd_sel0, bus.rd_sel1, bus.rd_sel2, bus.rd_sel3, bus.phase};
    endfunction

    function automatic logic [21:0] cur_all();
        return {bus.wr_sel, bus.rd_sel0, bus.rd_sel1, bus.rd_sel2, bus.rd_sel3,
                bus.phase, bus.line_go, bus.frame_done, bus.ovf};
    endfunction

    // Reference: output line i sits at position i*step; rows n-1..n+2 live in
    // buffers (row mod 5) with row -1 replicated from line 0.
    task automatic pushFrame(input int step, input int nlines);
        int s;
        s = (step == 0) ? 4096 : step;
        for (int i = 0; i < nlines; i++) begin
            int pos;
            int n;
            int ph;
            int m1;
            pos = i * s;
            n   = pos >> 12;
            ph  = (pos >> 8) & 15;
            m1  = (n == 0) ? 0 : n - 1;
            sb.push_back({3'(m1 % 5), 3'(n % 5), 3'((n + 1) % 5), 3'((n + 2) % 5), 4'(ph)});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // One-cycle pulse on vs_i and/or hs_i.
    task automatic applyStimulus(input bit vs, input bit hs);
        @(posedge clk);
        #1;
        bus.vs_i = vs;
        bus.hs_i = hs;
        @(posedge clk);
        #1;
        bus.vs_i = 1'b0;
        bus.hs_i = 1'b0;
    endtask

    task automatic hsPulses(input int count, input int gap);
        for (int i = 0; i < count; i++) begin
            applyStimulus(1'b0, 1'b1);
            idle(gap);
        end
    endtask

    task automatic startFrame(input int step, input int nlines, input bit with_hs);
        v_scale_step      = 16'(step);
        v_scale_line_size = 16'(nlines);
        sb.delete();
        pushFrame(step, nlines);
        applyStimulus(1'b1, with_hs);
    endtask

    task automatic waitFrameDone(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && fd_cnt < target; i++) @(negedge clk);
        checkOutput(tag, 32'(fd_cnt), 32'(target));
    endtask

    // Datapath model: answers each line_go with a one-cycle line_done.
    initial begin
        bus.line_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.line_go && done_delay != 0) begin
                repeat (done_delay) @(negedge clk);
                bus.line_done = 1'b1;
                @(negedge clk);
                bus.line_done = 1'b0;
            end
        end
    end

    // Scoreboard pop on every line_go; selects must hold between line_go pulses.
    always @(negedge clk) begin
        if (rst) begin
            last_sel = '0;
        end else begin
            if (bus.line_go) begin
                go_cnt++;
                if (sb.size() == 0) begin
                    checkOutput("go_without_line", 32'(sb.size()), 32'd1);
                end else begin
                    checkOutput("line_sel", 32'(cur_sel()), 32'(sb.pop_front()));
                end
                last_sel = cur_sel();
            end else if (cur_sel() !== last_sel) begin
                hold_bad++;
            end
            if (bus.frame_done) fd_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int go0;
        int fd0;
        rst               = 1'b1;
        bus.hs_i          = 1'b0;
        bus.vs_i          = 1'b0;
        v_scale_step      = '0;
        v_scale_line_size = '0;
        idle(3);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_init", 32'(cur_all()), 32'd0);

        $display("[TB] unity scale, 4 lines");
        done_delay = 5;
        go0 = go_cnt;
        fd0 = fd_cnt;
        startFrame(4096, 4, 1'b0);
        hsPulses(2, 0);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("go_early", 32'(bus.line_go), 32'd0);
        @(negedge clk);
        checkOutput("go_latency", 32'(bus.line_go), 32'd1);
        hsPulses(3, 12);
        waitFrameDone("frame_done_unity", fd0 + 1, 200);
        checkOutput("lines_unity", 32'(go_cnt - go0), 32'd4);
        checkOutput("sb_empty_unity", 32'(sb.size()), 32'd0);
        checkOutput("wr_sel_unity", 32'(bus.wr_sel), 32'd1);
        checkOutput("ovf_unity", 32'(bus.ovf), 32'd0);

        $display("[TB] upscale step 2048, 6 lines");
        fd0 = fd_cnt;
        startFrame(2048, 6, 1'b0);
        go0 = go_cnt;
        hsPulses(3, 40);
        checkOutput("go_per_hs_a", 32'(go_cnt - go0), 32'd2);
        go0 = go_cnt;
        hsPulses(1, 40);
        checkOutput("go_per_hs_b", 32'(go_cnt - go0), 32'd2);
        go0 = go_cnt;
        hsPulses(1, 40);
        checkOutput("go_per_hs_c", 32'(go_cnt - go0), 32'd2);
        waitFrameDone("frame_done_up", fd0 + 1, 200);
        checkOutput("sb_empty_up", 32'(sb.size()), 32'd0);

        $display("[TB] step 0 with vs and hs together, 3 lines");
        fd0 = fd_cnt;
        go0 = go_cnt;
        startFrame(0, 3, 1'b1);
        hsPulses(2, 0);
        idle(10);
        checkOutput("vs_beats_hs", 32'(go_cnt - go0), 32'd0);
        checkOutput("wr_sel_vs_hs", 32'(bus.wr_sel), 32'd2);
        hsPulses(3, 12);
        waitFrameDone("frame_done_step0", fd0 + 1, 200);
        checkOutput("lines_step0", 32'(go_cnt - go0), 32'd3);
        checkOutput("sb_empty_step0", 32'(sb.size()), 32'd0);

        $display("[TB] vs abort during BUSY");
        done_delay = 20;
        startFrame(4096, 4, 1'b0);
        hsPulses(3, 0);
        idle(6);
        fd0 = fd_cnt;
        startFrame(4096, 2, 1'b0);
        go0 = go_cnt;
        idle(30);
        checkOutput("no_fd_abort", 32'(fd_cnt), 32'(fd0));
        done_delay = 5;
        hsPulses(4, 12);
        waitFrameDone("frame_done_restart", fd0 + 1, 200);
        checkOutput("lines_restart", 32'(go_cnt - go0), 32'd2);
        checkOutput("sb_empty_restart", 32'(sb.size()), 32'd0);

        $display("[TB] downscale step 8192 with stalled datapath");
        done_delay = 0;
        go0 = go_cnt;
        startFrame(8192, 2, 1'b0);
        hsPulses(3, 2);
        hsPulses(3, 2);
        @(negedge clk);
        checkOutput("lines_stalled", 32'(go_cnt - go0), 32'd1);
        checkOutput("ovf_downscale", 32'(bus.ovf), 32'(OVF_EXP));

        $display("[TB] reset mid-frame");
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_mid", 32'(cur_all()), 32'd0);
        done_delay = 5;
        go0 = go_cnt;
        hsPulses(4, 4);
        idle(10);
        checkOutput("no_go_after_rst", 32'(go_cnt - go0), 32'd0);

        checkOutput("sel_hold", 32'(hold_bad), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scaler_v_ctrl.md
# scaler_v_ctrl

Line scheduler for the vertical scaler datapath. It tracks incoming video lines written into a ring of five line buffers and keeps a fixed-point vertical source position. For each output line it selects the four source buffers and the interpolation phase, then hands the line to the datapath with a go/done handshake. It sits beside the vertical scaler, between input video timing and the line-buffer read side.

## Interface
- PHASE_W, 4: interpolation phase bits (top bits of the 12-bit fraction)
- LINE_CNT_W, 12: width of source and output line counters
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- v_scale_step  in  16  source lines per output line, unsigned 4.12 (4096 = 1.0)
- v_scale_line_size  in  16  output lines per frame
- hs_i  in  1  one-cycle pulse at end of each source line
- vs_i  in  1  one-cycle pulse at frame start
- wr_sel  out  3  buffer currently written (0..4)
- rd_sel0..rd_sel3  out  3 each  buffers for source lines n-1, n, n+1, n+2
- phase  out  PHASE_W  coefficient phase
- line_go  out  1  one-cycle pulse: start output line
- line_done  in  1  one-cycle pulse from datapath: output line finished
- frame_done  out  1  one-cycle pulse when the last output line completes
- ovf  out  1  sticky: unread line overwritten

## Operation
- Config latching on vs_i:
  - step ← v_scale_step, with 0 replaced by 4096.
  - lines ← v_scale_line_size.
  - pos ← 0. pos is 24 bits: 12.12.
  - src_cnt ← 0, out_cnt ← 0, wr_sel ← 0.
  - FSM → WAIT.
- hs_i: src_cnt++ (saturating), wr_sel ← (wr_sel+1) mod 5.
- Let n = pos[23:12]. Source line k lives in buffer k mod 5.
- rd_selX = buffer of clamp(n-1+X, 0, src_cnt-1). Top row replicates line 0.
- phase = pos[11:12-PHASE_W].
- FSM states:
  - IDLE: after reset. Leaves only on vs_i.
  - WAIT: if out_cnt == lines → IDLE with frame_done. Else if src_cnt ≥ n+3 → ISSUE.
  - ISSUE: one cycle. Asserts line_go. rd_sel and phase are registered and held stable until line_done. → BUSY.
  - BUSY: on line_done, pos += step, out_cnt++, → WAIT.
- Overflow: if hs_i would make src_cnt − (n−1) > 5 while in BUSY or ISSUE, the line being read is clobbered. Data still flows (no stall possible on live video); see Configuration.
- vs_i in any state (including BUSY) aborts the frame and restarts as above. A line_done arriving after the abort is ignored.
- hs_i and line_done in the same cycle: both take effect.
- vs_i and hs_i in the same cycle: vs_i wins, src_cnt = 0.

## Timing
- Reset values: wr_sel=0, rd_sel*=0, phase=0, line_go=0, frame_done=0, ovf=0. FSM=IDLE.
- line_go is asserted 2 cycles after the hs_i that satisfies src_cnt ≥ n+3 (1 cycle to count, 1 cycle WAIT→ISSUE).
- Back-to-back lines: line_done → WAIT → ISSUE. Minimum 2 cycles from line_done to the next line_go.
- frame_done is asserted in the cycle WAIT detects out_cnt == lines.
- rd_sel* and phase change only on entry to ISSUE.

## Configuration
- SCALER_V_CTRL_OVF_DET_EN defined:
  - ovf sets on the overflow condition.
  - ovf clears only on rst.
- Not defined: ovf is tied to 0 and no comparison logic is built.

## Structure
- Package scaler_pkg holds:
  - NUM_LINE_BUF = 5
  - FRAC_W = 12
  - STEP_ONE = 4096
  - the FSM enum: IDLE, WAIT, ISSUE, BUSY
  - function buf_of(k) = k mod 5
- One sub-module, scaler_v_pos_acc:
  - pos accumulator with load-on-vs and add-on-done.
  - outputs n and phase.
- FSM, counters and select muxing stay in scaler_v_ctrl.

## Test plan
- Scale 1.0 (step 4096), lines=4, vs then 6 hs pulses, line_done 5 cycles after each line_go:
  - first line_go after the 3rd hs, with rd_sel = 0,0,1,2 and phase 0.
  - 4 lines total, then frame_done.
- Upscale step 2048, PHASE_W=4:
  - phases alternate 0, 8.
  - n advances every second line.
  - two line_go per source hs in steady state.
- Downscale step 8192 with no line_done for 3 hs periods: ovf=1 only when SCALER_V_CTRL_OVF_DET_EN is defined, otherwise 0.
- vs_i during BUSY:
  - FSM restarts.
  - the stale line_done is ignored.
  - no frame_done from the aborted frame.
- v_scale_step=0: behaves identically to 4096.
- rst asserted mid-frame: all outputs return to reset values next cycle, and no line_go until the next vs_i.
